// File: rtl/uart_word_tx.sv
// 8N1 UART transmitter for one 32-bit word per valid/ready handshake.
// Sends the low BYTES bytes, least-significant byte first, each byte LSB-first.
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 234,
  parameter int BYTES        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        tx,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [31:0]       shift_q, shift_d;
  logic              tx_q, tx_d;

  logic bit_tick;
  logic last_tick;
  logic accept;

  assign bit_tick  = (baud_q == BAUD_LAST);
  // Ready is raised during the final stop-bit cycle so a waiting word starts with no idle gap.
  assign last_tick = (state_q == STOP) && bit_tick && (byte_q == BYTE_LAST);

  assign data_ready = (state_q == IDLE) || last_tick;
  assign busy       = !data_ready;
  assign accept     = data_valid && data_ready;
  assign tx         = tx_q;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    baud_d  = (state_q == IDLE || bit_tick) ? '0 : baud_q + BAUD_W'(1);
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    tx_d    = tx_q;

    case (state_q)
      IDLE: ;
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (byte_q == BYTE_LAST) begin
            state_d = IDLE;
            byte_d  = '0;
          end else begin
            state_d = START;
            byte_d  = byte_q + BYTE_W'(1);
            tx_d    = 1'b0;
          end
        end
      end
    endcase

    // A new word overrides the end-of-frame return to IDLE.
    if (accept) begin
      state_d = START;
      baud_d  = '0;
      bit_d   = 3'd0;
      byte_d  = '0;
      shift_d = data_in;
      tx_d    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      byte_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: two instances (CPB=4/BYTES=4 and CPB=2/BYTES=1)
// compared cycle-by-cycle against a waveform model built from the 8N1 framing rules.
module tb_uart_word_tx;

  localparam int CPB_A = 4;
  localparam int NB_A  = 4;
  localparam int CPB_B = 2;
  localparam int NB_B  = 1;
  localparam int N_A   = NB_A * 10 * CPB_A;
  localparam int N_B   = NB_B * 10 * CPB_B;

  logic        clk = 1'b0;
  logic        rst_a, valid_a, ready_a, tx_a, busy_a;
  logic        rst_b, valid_b, ready_b, tx_b, busy_b;
  logic [31:0] data_a, data_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic cap_tx[$];
  logic cap_rdy[$];
  logic exp_tx[$];

  always #5 clk = ~clk;

  uart_word_tx #(.CLKS_PER_BIT(CPB_A), .BYTES(NB_A)) u_dut_a (
    .clk(clk), .rst(rst_a), .data_in(data_a), .data_valid(valid_a),
    .data_ready(ready_a), .tx(tx_a), .busy(busy_a)
  );

  uart_word_tx #(.CLKS_PER_BIT(CPB_B), .BYTES(NB_B)) u_dut_b (
    .clk(clk), .rst(rst_b), .data_in(data_b), .data_valid(valid_b),
    .data_ready(ready_b), .tx(tx_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected tx level for every cycle of one word's transmission.
  function automatic void model_word(input logic [31:0] w, input int cpb, input int nb);
    for (int b = 0; b < nb; b++) begin
      for (int r = 0; r < cpb; r++) exp_tx.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int r = 0; r < cpb; r++) exp_tx.push_back(w[8*b + i]);
      for (int r = 0; r < cpb; r++) exp_tx.push_back(1'b1);
    end
  endfunction

  function automatic void clear_all();
    cap_tx.delete();
    cap_rdy.delete();
    exp_tx.delete();
  endfunction

  task automatic capture(input bit sel, input int n);
    repeat (n) begin
      @(negedge clk);
      cap_tx.push_back(sel ? tx_b : tx_a);
      cap_rdy.push_back(sel ? ready_b : ready_a);
    end
  endtask

  // Called at a negedge; returns just after the accept edge. Valid is dropped unless hold is set.
  task automatic push(input bit sel, input logic [31:0] w, input bit hold);
    check(sel ? "ready_before_push_b" : "ready_before_push_a", sel ? ready_b : ready_a, 1);
    if (sel) begin data_b = w; valid_b = 1'b1; end
    else     begin data_a = w; valid_a = 1'b1; end
    @(posedge clk);
    #1;
    if (!hold) begin
      if (sel) valid_b = 1'b0;
      else     valid_a = 1'b0;
    end
  endtask

  task automatic compare_wave(input string tag);
    int mism = 0;
    check({tag, "_len"}, cap_tx.size(), exp_tx.size());
    for (int i = 0; i < cap_tx.size() && i < exp_tx.size(); i++)
      if (cap_tx[i] !== exp_tx[i]) mism++;
    check({tag, "_wave_mismatches"}, mism, 0);
  endtask

  // Recover bytes by sampling each data bit at its centre.
  task automatic decode_check(input string tag, input int cpb, input int nb, input int base,
                              input logic [31:0] w);
    logic [7:0] v;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 8; i++)
        v[i] = cap_tx[base + b*10*cpb + (1 + i)*cpb + cpb/2];
      check($sformatf("%s_byte%0d", tag, b), {24'h0, v}, {24'h0, w[8*b +: 8]});
    end
  endtask

  // Edges from accept until the next edge able to accept a word.
  task automatic period_check(input string tag, input int n);
    int first_hi = -1;
    for (int i = 0; i < cap_rdy.size(); i++)
      if (first_hi < 0 && cap_rdy[i] === 1'b1) first_hi = i;
    check({tag, "_accept_period"}, first_hi + 1, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic        pat[10];
    int          mism;

    rst_a = 1'b1; rst_b = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0;
    data_a = '0; data_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx_a", tx_a, 1);
    check("rst_ready_a", ready_a, 1);
    check("rst_busy_a", busy_a, 0);
    check("rst_tx_b", tx_b, 1);
    check("rst_ready_b", ready_b, 1);
    check("rst_busy_b", busy_b, 0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Basic word, byte order and ready timing.
    @(negedge clk);
    clear_all();
    push(0, 32'h12345678, 0);
    capture(0, N_A);
    model_word(32'h12345678, CPB_A, NB_A);
    compare_wave("t1");
    decode_check("t1", CPB_A, NB_A, 0, 32'h12345678);
    period_check("t1", N_A);
    check("t1_busy_mid", cap_rdy[N_A/2], 0);

    // Literal bit pattern of the first byte 0x78.
    pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    mism = 0;
    for (int j = 0; j < 10*CPB_A; j++)
      if (cap_tx[j] !== pat[j/CPB_A]) mism++;
    check("t2_byte78_pattern", mism, 0);

    // Back-to-back words with data_valid held high.
    clear_all();
    push(0, 32'hA5A5A5A5, 1);
    data_a = 32'h0000FF01;
    capture(0, 2*N_A);
    valid_a = 1'b0;
    model_word(32'hA5A5A5A5, CPB_A, NB_A);
    model_word(32'h0000FF01, CPB_A, NB_A);
    compare_wave("t3");
    decode_check("t3_w0", CPB_A, NB_A, 0, 32'hA5A5A5A5);
    decode_check("t3_w1", CPB_A, NB_A, N_A, 32'h0000FF01);
    check("t3_second_accepted", cap_rdy[N_A], 0);

    // Mid-frame data change and valid pulse are ignored.
    @(negedge clk);
    clear_all();
    w = $urandom;
    push(0, w, 0);
    capture(0, 50);
    data_a = 32'hFFFFFFFF;
    valid_a = 1'b1;
    capture(0, 1);
    valid_a = 1'b0;
    capture(0, N_A - 51);
    model_word(w, CPB_A, NB_A);
    compare_wave("t4");
    decode_check("t4", CPB_A, NB_A, 0, w);
    cap_tx.delete(); cap_rdy.delete();
    capture(0, 10);
    mism = 0;
    for (int i = 0; i < 10; i++)
      if (cap_tx[i] !== 1'b1 || cap_rdy[i] !== 1'b1) mism++;
    check("t4_no_reaccept", mism, 0);

    // Reset during DATA of byte 2, then a fresh word.
    clear_all();
    w = $urandom;
    push(0, w, 0);
    capture(0, 2*10*CPB_A + 3*CPB_A);
    rst_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_rst_tx", tx_a, 1);
    check("t5_rst_ready", ready_a, 1);
    check("t5_rst_busy", busy_a, 0);
    rst_a = 1'b0;
    clear_all();
    push(0, 32'h00000055, 0);
    capture(0, N_A);
    model_word(32'h00000055, CPB_A, NB_A);
    compare_wave("t5");
    decode_check("t5", CPB_A, NB_A, 0, 32'h00000055);

    // Random words with random idle gaps.
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      clear_all();
      w = $urandom;
      push(0, w, 0);
      capture(0, N_A);
      model_word(w, CPB_A, NB_A);
      compare_wave($sformatf("rand%0d", k));
      decode_check($sformatf("rand%0d", k), CPB_A, NB_A, 0, w);
      period_check($sformatf("rand%0d", k), N_A);
    end

    // Single-byte instance: upper bytes discarded.
    @(negedge clk);
    clear_all();
    push(1, 32'hDEADBE3C, 0);
    capture(1, N_B);
    model_word(32'hDEADBE3C, CPB_B, NB_B);
    compare_wave("t6");
    decode_check("t6", CPB_B, NB_B, 0, 32'hDEADBE3C);
    period_check("t6", N_B);
    cap_tx.delete(); cap_rdy.delete();
    capture(1, 6);
    mism = 0;
    for (int i = 0; i < 6; i++)
      if (cap_tx[i] !== 1'b1) mism++;
    check("t6_idle_after", mism, 0);

    for (int k = 0; k < 3; k++) begin
      clear_all();
      w = $urandom;
      push(1, w, 0);
      capture(1, N_B);
      model_word(w, CPB_B, NB_B);
      compare_wave($sformatf("rand_b%0d", k));
      period_check($sformatf("rand_b%0d", k), N_B);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
